jtframe_dip_bank: RTL and testbench
===================================

Name: jtframe_dip_bank

Overview:
Parametrised DIP-switch bank manager sitting between the OSD status word and the game core. It generalises fixed DIP handling to NBANK 8-bit banks. Each bank is settled (debounced against OSD scrolling) before being committed, and a game reset is requested when a reset-sensitive bank changes. It also exposes a serial shift-out port for boards that read DIPs through a shift register, and owns the pause toggle.

Parameters:
NBANK, 4, number of 8-bit DIP banks; DW = 8*NBANK.
DEF_MASK, {DW{1'b1}}, XOR mask applied to status so an all-zero OSD word yields factory DIP levels (DIPs active low).
RST_MASK, {NBANK{1'b0}}, bit b=1: a committed change in bank b requests a game reset.
SETTLEW, 10, settle counter width; status must be stable 2^SETTLEW cycles before commit.
RSTLEN, 16, game reset pulse length in cycles (1..255).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
status  in  DW  raw OSD DIP bits, bank b = status[8b+7:8b]
pause_btn  in  1  keyboard/gamepad pause key, level, active high
osd_pause  in  1  OSD pause request, level, active high
dip_out  out  DW  committed DIP levels = committed status ^ DEF_MASK
dip_ok  out  1  high once the first commit after reset has happened
game_rst  out  1  game reset request pulse, active high
dip_pause  out  1  pause to game, active low
ser_ld  in  1  serial snapshot load
ser_sh  in  1  serial shift strobe (one-cycle pulse per bit)
ser_dout  out  1  serial data, MSB of shift register

Behaviour:
- Reset values: dip_out=DEF_MASK, dip_ok=0, game_rst=0, dip_pause=1, shift register all 1s (ser_dout=1), FSM=SETTLE, counter=0, shadow=status, first flag=1.
- Shadow register samples status every cycle. "changed" = status != shadow.
- FSM states IDLE, SETTLE, COMMIT, RSTP.
- IDLE: changed -> SETTLE, counter cleared.
- SETTLE: changed -> counter cleared, stay. Else counter increments; at all-ones -> COMMIT. Commit occurs exactly 2^SETTLEW cycles after the last status change.
- COMMIT (one cycle): dip_out <= shadow ^ DEF_MASK; dip_ok <= 1. Bank diff is computed per bank against the previous dip_out.
  - If first=0 and any differing bank has RST_MASK=1 -> RSTP with game_rst asserted next cycle.
  - Otherwise -> IDLE.
  - first <= 0. The first commit after reset never pulses game_rst.
- RSTP: game_rst held high exactly RSTLEN cycles, then -> IDLE (or SETTLE if changed). Status changes during RSTP do not shorten the pulse; they are handled after it.
- Entering RSTP clears the pause toggle.
- Pause: rising edge of pause_btn (registered edge detect) toggles pause_tgl. dip_pause = ~(pause_tgl | osd_pause), registered (1-cycle latency).
- Serial: ser_ld=1 loads shift register with dip_out (same-cycle value, i.e. value before any same-cycle commit). ser_sh=1 shifts left, filling the LSB with 1. ser_ld wins over ser_sh in the same cycle. After DW shifts ser_dout stays 1. ser_dout is the register MSB, so the bit is visible the cycle after the load or shift.
- Reset mid-settle or mid-pulse: immediate return to reset values; any pending commit is discarded.

Test Plan:
- Reset with status=0, NBANK=2, DEF_MASK=16'hFFFF -> dip_out=FFFF during settle; after 1024 cycles dip_out=FFFF, dip_ok=1, game_rst never high.
- status bank0 0x00->0x01 (RST_MASK=2'b01) -> dip_out=FFFE exactly 1024 cycles later, then game_rst high for 16 cycles.
- Bank1 change only (RST_MASK=2'b01) -> dip_out updates, game_rst stays 0. Status toggling every 500 cycles -> no commit until stable for 1024 cycles.
- Pulse pause_btn twice -> dip_pause 1->0->1. Hold osd_pause -> dip_pause=0 regardless of the toggle. Reset pulse clears the toggle.
- dip_out=16'hA5C3, ser_ld then 16 ser_sh -> ser_dout sequence 1010010111000011, then 1s. ser_ld and ser_sh in the same cycle -> load.
- rst asserted at settle count 600 -> dip_out=DEF_MASK and dip_ok=0; no game_rst on the subsequent first commit.

Source files
------------

// File: rtl/jtframe_dip_bank_if.sv
// jtframe_dip_bank_if
// Bundles the OSD-side and game-side signals of the DIP bank manager.
//   status    : raw OSD DIP bits, bank b = status[8b+7:8b]
//   pause_btn : pause key level, osd_pause : OSD pause request level
//   dip_out   : committed DIP levels, dip_ok : first commit done
//   game_rst  : game reset pulse, dip_pause : pause to game (active low)
//   ser_ld / ser_sh / ser_dout : shift-register style DIP read-out
// master drives the inputs of the manager; slave is the manager itself.
interface jtframe_dip_bank_if #(
  parameter int DW = 32
);
  logic [DW-1:0] status;
  logic          pause_btn;
  logic          osd_pause;
  logic [DW-1:0] dip_out;
  logic          dip_ok;
  logic          game_rst;
  logic          dip_pause;
  logic          ser_ld;
  logic          ser_sh;
  logic          ser_dout;

  modport master (
    output status, pause_btn, osd_pause, ser_ld, ser_sh,
    input  dip_out, dip_ok, game_rst, dip_pause, ser_dout
  );

  modport slave (
    input  status, pause_btn, osd_pause, ser_ld, ser_sh,
    output dip_out, dip_ok, game_rst, dip_pause, ser_dout
  );
endinterface

// File: rtl/jtframe_dip_bank.sv
// jtframe_dip_bank
// DIP-switch bank manager between the OSD status word and the game core.
// NBANK 8-bit banks are committed only after the OSD word has been stable
// for 2^SETTLEW cycles; a committed change in a bank flagged in RST_MASK
// raises game_rst for RSTLEN cycles (never on the first commit after reset).
// Also owns the pause toggle and a serial shift-out copy of dip_out.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : jtframe_dip_bank_if slave (status, pause, dip_out, serial)
module jtframe_dip_bank #(
  parameter int                   NBANK    = 4,
  parameter logic [8*NBANK-1:0]   DEF_MASK = {8*NBANK{1'b1}},
  parameter logic [NBANK-1:0]     RST_MASK = {NBANK{1'b0}},
  parameter int                   SETTLEW  = 10,
  parameter int                   RSTLEN   = 16
) (
  input  logic            clk,
  input  logic            rst,
  jtframe_dip_bank_if.slave bus
);

  localparam int DW = 8 * NBANK;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_RSTP   = 2'd3;

  logic [1:0]         state_q,    state_d;
  logic [SETTLEW-1:0] cnt_q,      cnt_d;
  logic [7:0]         rcnt_q,     rcnt_d;
  logic               dirty_q,    dirty_d;
  logic [DW-1:0]      shadow_q;
  logic [DW-1:0]      dip_q,      dip_d;
  logic               ok_q,       ok_d;
  logic               first_q,    first_d;
  logic               game_rst_q, game_rst_d;
  logic               btn_q;
  logic               tgl_q,      tgl_d;
  logic               pause_q,    pause_d;
  logic [DW-1:0]      sr_q,       sr_d;

  logic               changed;
  logic               go_rst;
  logic               enter_rstp;
  logic [NBANK-1:0]   bank_diff;

  assign changed = (bus.status != shadow_q);

  // Per-bank difference between the value about to be committed and the
  // levels currently presented to the game.
  genvar gi;
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      assign bank_diff[gi] = |((shadow_q[8*gi +: 8] ^ DEF_MASK[8*gi +: 8])
                               ^ dip_q[8*gi +: 8]);
    end
  endgenerate

  assign go_rst = !first_q && |(bank_diff & RST_MASK);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    dirty_d    = dirty_q;
    dip_d      = dip_q;
    ok_d       = ok_q;
    first_d    = first_q;
    enter_rstp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (changed) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (changed) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        dip_d   = shadow_q ^ DEF_MASK;
        ok_d    = 1'b1;
        first_d = 1'b0;
        if (go_rst) begin
          state_d    = ST_RSTP;
          rcnt_d     = '0;
          // the shadow moves on this edge, so remember a change seen now
          dirty_d    = changed;
          enter_rstp = 1'b1;
        end else if (changed) begin
          // a change landing on the commit cycle must not be lost
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin // ST_RSTP
        dirty_d = dirty_q | changed;
        if (rcnt_q == 8'(RSTLEN - 1)) begin
          dirty_d = 1'b0;
          if (changed || dirty_q) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          rcnt_d = rcnt_q + 8'd1;
        end
      end
    endcase
  end

  assign game_rst_d = (state_d == ST_RSTP);

  // Pause: toggle on the rising edge of the key; a game reset clears it.
  always_comb begin
    tgl_d = tgl_q;
    if (enter_rstp)                  tgl_d = 1'b0;
    else if (bus.pause_btn && !btn_q) tgl_d = ~tgl_q;
  end

  assign pause_d = ~(tgl_q | bus.osd_pause);

  // Serial read-out: load has priority; shifting fills with ones.
  always_comb begin
    sr_d = sr_q;
    if (bus.ser_ld)      sr_d = dip_q;
    else if (bus.ser_sh) sr_d = {sr_q[DW-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SETTLE;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      dirty_q    <= 1'b0;
      shadow_q   <= bus.status;
      dip_q      <= DEF_MASK;
      ok_q       <= 1'b0;
      first_q    <= 1'b1;
      game_rst_q <= 1'b0;
      btn_q      <= 1'b0;
      tgl_q      <= 1'b0;
      pause_q    <= 1'b1;
      sr_q       <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      dirty_q    <= dirty_d;
      shadow_q   <= bus.status;
      dip_q      <= dip_d;
      ok_q       <= ok_d;
      first_q    <= first_d;
      game_rst_q <= game_rst_d;
      btn_q      <= bus.pause_btn;
      tgl_q      <= tgl_d;
      pause_q    <= pause_d;
      sr_q       <= sr_d;
    end
  end

  assign bus.dip_out   = dip_q;
  assign bus.dip_ok    = ok_q;
  assign bus.game_rst  = game_rst_q;
  assign bus.dip_pause = pause_q;
  assign bus.ser_dout  = sr_q[DW-1];

endmodule

// File: tb/tb_jtframe_dip_bank.sv
// tb_jtframe_dip_bank
// Directed scenarios with literal expectations followed by a random phase.
// A behavioural model tracks, per clock edge, when the next commit is due
// (edge of last accepted change + 2^SETTLEW + 1), how much of the reset
// pulse is left, the pause toggle and the serial snapshot; a compare
// process checks every DUT output against it on each falling edge.
module tb_jtframe_dip_bank;

  localparam int          NBANK = 2;
  localparam int          DW    = 16;
  localparam logic [15:0] DEF   = 16'hFFFF;
  localparam logic [1:0]  RMASK = 2'b01;
  localparam int          SW    = 10;
  localparam int          RL    = 16;
  localparam int          SN    = 1 << SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtframe_dip_bank_if #(.DW(DW)) bus ();

  jtframe_dip_bank #(
    .NBANK(NBANK), .DEF_MASK(DEF), .RST_MASK(RMASK),
    .SETTLEW(SW), .RSTLEN(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  logic          m_valid = 1'b0;
  longint        m_t = 0;
  longint        m_commit_at = 0;
  logic          m_pending = 1'b0;
  logic [DW-1:0] m_prev = '0, m_pend_val = '0, m_dip = '0, m_sr = '0;
  logic          m_ok = 1'b0, m_first = 1'b0, m_dirty = 1'b0;
  logic          m_tgl = 1'b0, m_btn_prev = 1'b0, m_pause = 1'b1;
  int            m_pulse_left = 0;

  task automatic arm();
    m_pending   = 1'b1;
    m_commit_at = m_t + SN + 1;
    m_pend_val  = bus.status;
  endtask

  task automatic model_step();
    logic chg, rise, enter, hit;
    m_t++;
    if (rst) begin
      m_valid = 1'b1; m_prev = bus.status; m_dip = DEF; m_ok = 1'b0;
      m_first = 1'b1; m_dirty = 1'b0; m_tgl = 1'b0; m_btn_prev = 1'b0;
      m_pause = 1'b1; m_pulse_left = 0; m_sr = '1;
      arm();
    end else if (m_valid) begin
      chg    = (bus.status != m_prev);
      m_prev = bus.status;
      if (bus.ser_ld)      m_sr = m_dip;
      else if (bus.ser_sh) m_sr = (m_sr << 1) | 16'd1;
      m_pause    = ~(m_tgl | bus.osd_pause);
      rise       = bus.pause_btn & ~m_btn_prev;
      m_btn_prev = bus.pause_btn;
      enter      = 1'b0;
      if (m_pulse_left > 0) begin
        m_dirty = m_dirty | chg;
        m_pulse_left--;
        if (m_pulse_left == 0) begin
          if (m_dirty) arm();
          m_dirty = 1'b0;
        end
      end else if (m_pending && m_t == m_commit_at) begin
        hit = 1'b0;
        for (int b = 0; b < NBANK; b++)
          if (((m_pend_val[8*b +: 8] ^ DEF[8*b +: 8]) != m_dip[8*b +: 8]) && RMASK[b])
            hit = 1'b1;
        m_dip     = m_pend_val ^ DEF;
        m_ok      = 1'b1;
        m_pending = 1'b0;
        if (hit && !m_first) begin
          m_pulse_left = RL;
          enter        = 1'b1;
          m_dirty      = chg;
        end else if (chg) begin
          arm();
        end
        m_first = 1'b0;
      end else if (chg) begin
        arm();
      end
      if (enter)     m_tgl = 1'b0;
      else if (rise) m_tgl = ~m_tgl;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      checks++;
      if ({bus.dip_out, bus.dip_ok, bus.game_rst, bus.dip_pause, bus.ser_dout} !==
          {m_dip, m_ok, (m_pulse_left > 0), m_pause, m_sr[DW-1]}) begin
        errors++;
        $display("FAIL cycle t=%0d: dut dip=%h ok=%b rst=%b pause=%b ser=%b, model dip=%h ok=%b rst=%b pause=%b ser=%b",
                 m_t, bus.dip_out, bus.dip_ok, bus.game_rst, bus.dip_pause, bus.ser_dout,
                 m_dip, m_ok, (m_pulse_left > 0), m_pause, m_sr[DW-1]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles (falling edges) from now until dip_out moves; bounded.
  task automatic wait_dip_change(output int n);
    logic [DW-1:0] old;
    old = bus.dip_out;
    n = 0;
    while (bus.dip_out == old && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_rst(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.game_rst) c++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_sh();
    bus.ser_sh = 1'b1; tick(1); bus.ser_sh = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, c;
    logic [15:0] bits;
    bus.status = '0; bus.pause_btn = 1'b0; bus.osd_pause = 1'b0;
    bus.ser_ld = 1'b0; bus.ser_sh = 1'b0;
    rst = 1'b1;
    tick(3);
    check("reset_dip_out", bus.dip_out, 16'hFFFF);
    check("reset_dip_ok", bus.dip_ok, 0);
    check("reset_game_rst", bus.game_rst, 0);
    check("reset_dip_pause", bus.dip_pause, 1);
    check("reset_ser_dout", bus.ser_dout, 1);
    rst = 1'b0;

    // first commit: factory levels, no reset pulse
    c = 0;
    for (int i = 0; i < 1100; i++) begin
      if (bus.game_rst) c++;
      tick(1);
    end
    check("first_commit_dip_out", bus.dip_out, 16'hFFFF);
    check("first_commit_dip_ok", bus.dip_ok, 1);
    check("first_commit_no_rst", c, 0);

    // bank0 change: COMMIT entered 1024 edges after the change edge,
    // dip_out visible one edge later, i.e. 1026 falling edges from here
    bus.status = 16'h0001;
    wait_dip_change(n);
    check("bank0_latency", n, 1026);
    check("bank0_dip_out", bus.dip_out, 16'hFFFE);
    check("model_pin_dip", m_dip, 16'hFFFE);
    count_rst(40, c);
    check("bank0_rst_len", c, 16);

    // bank1 change: not reset sensitive
    bus.status = 16'h0101;
    wait_dip_change(n);
    check("bank1_latency", n, 1026);
    check("bank1_dip_out", bus.dip_out, 16'hFEFE);
    count_rst(40, c);
    check("bank1_no_rst", c, 0);

    // status moving every 500 cycles holds off the commit
    bus.status = 16'h0201; tick(500);
    check("toggle_hold_a", bus.dip_out, 16'hFEFE);
    bus.status = 16'h0301; tick(500);
    check("toggle_hold_b", bus.dip_out, 16'hFEFE);
    bus.status = 16'h0401;
    wait_dip_change(n);
    check("toggle_latency", n, 1026);
    check("toggle_dip_out", bus.dip_out, 16'hFBFE);

    // pause toggle and OSD override
    bus.pause_btn = 1'b1; tick(1); bus.pause_btn = 1'b0; tick(3);
    check("pause_on", bus.dip_pause, 0);
    bus.pause_btn = 1'b1; tick(1); bus.pause_btn = 1'b0; tick(3);
    check("pause_off", bus.dip_pause, 1);
    bus.osd_pause = 1'b1; tick(3);
    check("osd_pause_hold", bus.dip_pause, 0);
    bus.pause_btn = 1'b1; tick(1); bus.pause_btn = 1'b0; tick(3);
    check("osd_pause_with_tgl", bus.dip_pause, 0);
    bus.osd_pause = 1'b0; tick(3);
    check("tgl_still_on", bus.dip_pause, 0);
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    check("reset_clears_tgl", bus.dip_pause, 1);
    check("reset_again_dip_out", bus.dip_out, 16'hFFFF);

    n = 0;
    while (!bus.dip_ok && n < 1200) begin tick(1); n++; end
    check("recommit_dip_out", bus.dip_out, 16'hFBFE);

    // serial read-out of A5C3
    bus.status = 16'h5A3C;
    wait_dip_change(n);
    check("serial_dip_out", bus.dip_out, 16'hA5C3);
    count_rst(40, c);
    check("serial_setup_rst_len", c, 16);
    bus.ser_ld = 1'b1; tick(1); bus.ser_ld = 1'b0;
    bits[15] = bus.ser_dout;
    for (int i = 14; i >= 0; i--) begin
      pulse_sh();
      bits[i] = bus.ser_dout;
    end
    check("serial_sequence", bits, 16'hA5C3);
    pulse_sh();
    check("serial_fill_1", bus.ser_dout, 1);
    pulse_sh(); pulse_sh();
    check("serial_fill_3", bus.ser_dout, 1);
    bus.ser_ld = 1'b1; tick(1); bus.ser_ld = 1'b0;
    pulse_sh(); pulse_sh(); pulse_sh();
    check("serial_bit12", bus.ser_dout, 0);
    bus.ser_ld = 1'b1; bus.ser_sh = 1'b1; tick(1);
    bus.ser_ld = 1'b0; bus.ser_sh = 1'b0;
    check("serial_ld_wins", bus.ser_dout, 1);
    pulse_sh();
    check("serial_after_ld_wins", bus.ser_dout, 0);

    // reset in the middle of a settle
    bus.status = 16'h0033;
    tick(600);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("midsettle_dip_out", bus.dip_out, 16'hFFFF);
    check("midsettle_dip_ok", bus.dip_ok, 0);
    n = 0; c = 0;
    while (!bus.dip_ok && n < 1200) begin
      if (bus.game_rst) c++;
      tick(1); n++;
    end
    check("midsettle_commit", bus.dip_out, 16'hFFCC);
    count_rst(40, n);
    check("midsettle_no_rst", c + n, 0);

    // random phase, checked by the model every cycle
    for (int i = 0; i < 24000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r == 0)      bus.status = 16'($urandom);
      else if (r == 1) bus.status = bus.status ^ (16'hFF << (8 * $urandom_range(0, 1)));
      else if (r == 2) bus.status = bus.status ^ 16'($urandom_range(1, 255));
      if (bus.game_rst && $urandom_range(0, 7) == 0)
        bus.status = bus.status ^ 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 15) == 0) bus.pause_btn = ~bus.pause_btn;
      if ($urandom_range(0, 199) == 0) bus.osd_pause = ~bus.osd_pause;
      bus.ser_ld = ($urandom_range(0, 19) == 0);
      bus.ser_sh = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 14999) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
